// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its two-requester round-robin front end.
package alu_pkg;

  localparam int ALU_DATA_W = 32;

  localparam logic [2:0] ALU_ZERO0 = 3'b000;
  localparam logic [2:0] ALU_ZERO1 = 3'b001;
  localparam logic [2:0] ALU_ADD   = 3'b010;
  localparam logic [2:0] ALU_SUB   = 3'b011;
  localparam logic [2:0] ALU_SLL   = 3'b100;
  localparam logic [2:0] ALU_SRL   = 3'b101;
  localparam logic [2:0] ALU_ADD2  = 3'b110;
  localparam logic [2:0] ALU_SUB2  = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU: wrapping add/sub, logical shifts by the full
// operand2 value (so shift amounts of 32 or more give zero).
module alu
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W
) (
  input  logic [2:0]        alu_op_i,
  input  logic [DATA_W-1:0] operand1_i,
  input  logic [DATA_W-1:0] operand2_i,
  output logic [DATA_W-1:0] result_o
);

  // Opcode decode; the two zero opcodes fall through to the default
  always_comb begin
    result_o = '0;
    case (alu_op_i)
      ALU_ADD, ALU_ADD2: result_o = operand1_i + operand2_i;
      ALU_SUB, ALU_SUB2: result_o = operand1_i - operand2_i;
      ALU_SLL:           result_o = operand1_i << operand2_i;
      ALU_SRL:           result_o = operand1_i >> operand2_i;
      default:           result_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters. A granted
// request is latched, executed for one cycle, and returned on a single
// registered response channel tagged with the owning requester.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int   DATA_W    = ALU_DATA_W,
  parameter logic PRIO_INIT = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [2:0]        req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [2:0]        req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_id,
  output logic [DATA_W-1:0] resp_result,
  output logic              busy
);

  logic [1:0]        state_q, state_d;
  logic              prio_q, prio_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_id_q, resp_id_d;
  logic [DATA_W-1:0] resp_result_q, resp_result_d;

  logic [2:0]        op_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic              id_q;

  logic              window, grant0, grant1, accept;
  logic [DATA_W-1:0] alu_result;

  // Grant selection: a lone requester always wins, a tie goes to prio_q.
  // Readies are held low while reset is asserted so nothing is accepted.
  always_comb begin
    window     = !rst && ((state_q == ST_IDLE) ||
                          ((state_q == ST_RESP) && resp_ready));
    grant0     = req0_valid && (!req1_valid || (prio_q == 1'b0));
    grant1     = req1_valid && (!req0_valid || (prio_q == 1'b1));
    accept     = window && (grant0 || grant1);
    req0_ready = window && grant0;
    req1_ready = window && grant1;
  end

  // Next state; RESP can hand straight back to EXEC when a new request
  // is accepted on the same edge the response is consumed
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (resp_ready) state_d = accept ? ST_EXEC : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Priority flips to the loser of every accept; response regs load in EXEC
  always_comb begin
    prio_d        = accept ? grant0 : prio_q;
    resp_valid_d  = resp_valid_q;
    resp_id_d     = resp_id_q;
    resp_result_d = resp_result_q;
    if (state_q == ST_EXEC) begin
      resp_valid_d  = 1'b1;
      resp_id_d     = id_q;
      resp_result_d = alu_result;
    end else if ((state_q == ST_RESP) && resp_ready) begin
      resp_valid_d  = 1'b0;
    end else if (state_q != ST_RESP) begin
      resp_valid_d  = 1'b0;
    end
  end

  // Control and response registers; reset discards any in-flight operation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      prio_q        <= PRIO_INIT;
      resp_valid_q  <= 1'b0;
      resp_id_q     <= 1'b0;
      resp_result_q <= '0;
    end else begin
      state_q       <= state_d;
      prio_q        <= prio_d;
      resp_valid_q  <= resp_valid_d;
      resp_id_q     <= resp_id_d;
      resp_result_q <= resp_result_d;
    end
  end

  // Payload capture of the granted request; pure data, no reset needed
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q <= grant0 ? req0_op : req1_op;
      a_q  <= grant0 ? req0_a  : req1_a;
      b_q  <= grant0 ? req0_b  : req1_b;
      id_q <= grant1;
    end
  end

  alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .alu_op_i   (op_q),
    .operand1_i (a_q),
    .operand2_i (b_q),
    .result_o   (alu_result)
  );

  assign resp_valid  = resp_valid_q;
  assign resp_id     = resp_id_q;
  assign resp_result = resp_result_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: reset, vector table, contention, backpressure,
// overlap, reset mid-operation, then random traffic against a model.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready;
  logic [2:0]  req0_op;
  logic [31:0] req0_a, req0_b;
  logic        req1_valid, req1_ready;
  logic [2:0]  req1_op;
  logic [31:0] req1_a, req1_b;
  logic        resp_valid, resp_ready, resp_id;
  logic [31:0] resp_result;
  logic        busy;

  int unsigned total = 0;
  int unsigned bad   = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  always #5 clk = ~clk;

  alu_arbiter #(
    .DATA_W    (32),
    .PRIO_INIT (1'b0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_op     (req0_op),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_op     (req1_op),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_id     (resp_id),
    .resp_result (resp_result),
    .busy        (busy)
  );

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%b required=%b t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] r;
    case (op)
      3'd2, 3'd6: r = a + b;
      3'd3, 3'd7: r = a - b;
      3'd4:       r = (b > 32'd31) ? 32'd0 : (a << b[4:0]);
      3'd5:       r = (b > 32'd31) ? 32'd0 : (a >> b[4:0]);
      default:    r = 32'd0;
    endcase
    return r;
  endfunction

  // Single request on requester 0 from IDLE, response consumed immediately
  task automatic run_single(input string nm, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp);
    req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    resp_ready = 1'b1;
    #1;
    chk1({nm, "_rdy0"}, req0_ready, 1'b1);
    chk1({nm, "_rdy1"}, req1_ready, 1'b0);
    tick();
    req0_valid = 1'b0;
    #1;
    chk1({nm, "_exec_busy"}, busy, 1'b1);
    chk1({nm, "_exec_rv"}, resp_valid, 1'b0);
    chk1({nm, "_exec_rdy0"}, req0_ready, 1'b0);
    tick();
    #1;
    chk1({nm, "_rv"}, resp_valid, 1'b1);
    chk32({nm, "_res"}, resp_result, exp);
    chk1({nm, "_id"}, resp_id, 1'b0);
    tick();
  endtask

  // Random-phase model: transaction-level view of the arbiter
  logic        pv[2];
  logic [2:0]  pop[2];
  logic [31:0] pa[2], pb[2];
  logic        m_prio, m_inflight, m_shown, m_id;
  logic [31:0] m_res;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{3'b010, 32'd5,         32'd7,  32'd12};
    vecs[1] = '{3'b010, 32'hFFFFFFFF,  32'd1,  32'd0};
    vecs[2] = '{3'b011, 32'd0,         32'd1,  32'hFFFFFFFF};
    vecs[3] = '{3'b100, 32'd1,         32'd32, 32'd0};
    vecs[4] = '{3'b101, 32'h80000000,  32'd31, 32'd1};
    vecs[5] = '{3'b000, 32'h1234,      32'h5678, 32'd0};
    vecs[6] = '{3'b001, 32'hDEADBEEF,  32'd9,  32'd0};
    vecs[7] = '{3'b111, 32'd10,        32'd3,  32'd7};
    vecs[8] = '{3'b110, 32'h7FFFFFFF,  32'd1,  32'h80000000};
    vecs[9] = '{3'b100, 32'd3,         32'd4,  32'd48};

    // Reset with both requesters asking: nothing may be accepted
    rst = 1'b1;
    resp_ready = 1'b1;
    req0_valid = 1'b1; req0_op = 3'b011; req0_a = 32'd10; req0_b = 32'd3;
    req1_valid = 1'b1; req1_op = 3'b100; req1_a = 32'd1;  req1_b = 32'd4;
    repeat (2) @(negedge clk);
    #1;
    chk1("rst_rdy0", req0_ready, 1'b0);
    chk1("rst_rdy1", req1_ready, 1'b0);
    chk1("rst_rv", resp_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_id", resp_id, 1'b0);
    chk32("rst_res", resp_result, 32'd0);
    rst = 1'b0;

    // Contention from reset: grants alternate 0,1,0,1
    for (int k = 0; k < 4; k++) begin
      #1;
      chk1("cont_rdy0", req0_ready, (k % 2) == 0);
      chk1("cont_rdy1", req1_ready, (k % 2) == 1);
      tick();
      #1;
      chk1("cont_exec_busy", busy, 1'b1);
      chk1("cont_exec_rdy0", req0_ready, 1'b0);
      chk1("cont_exec_rdy1", req1_ready, 1'b0);
      tick();
      #1;
      chk1("cont_rv", resp_valid, 1'b1);
      chk1("cont_id", resp_id, (k % 2) == 1);
      chk32("cont_res", resp_result, ((k % 2) == 1) ? 32'd16 : 32'd7);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    #1;
    chk1("cont_idle_busy", busy, 1'b0);
    chk1("cont_idle_rv", resp_valid, 1'b0);

    // Table of single operations including arithmetic edges
    for (int i = 0; i < 10; i++)
      run_single($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);

    // Backpressure: response held 5 cycles, then back-to-back accept of req1
    req0_valid = 1'b1; req0_op = 3'b010; req0_a = 32'd1; req0_b = 32'd2;
    resp_ready = 1'b0;
    #1;
    chk1("bp_rdy0", req0_ready, 1'b1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_op = 3'b011; req1_a = 32'd9; req1_b = 32'd4;
    #1;
    chk1("bp_exec_rdy1", req1_ready, 1'b0);
    tick();
    for (int k = 0; k < 5; k++) begin
      #1;
      chk1("bp_rv", resp_valid, 1'b1);
      chk32("bp_res", resp_result, 32'd3);
      chk1("bp_id", resp_id, 1'b0);
      chk1("bp_rdy0", req0_ready, 1'b0);
      chk1("bp_rdy1", req1_ready, 1'b0);
      chk1("bp_busy", busy, 1'b1);
      tick();
    end
    resp_ready = 1'b1;
    #1;
    chk1("bp_rel_rdy1", req1_ready, 1'b1);
    chk32("bp_rel_res", resp_result, 32'd3);
    tick();
    req1_valid = 1'b0;
    #1;
    chk1("bp_b2b_busy", busy, 1'b1);
    chk1("bp_b2b_rv", resp_valid, 1'b0);
    tick();
    #1;
    chk1("bp_b2b_rv2", resp_valid, 1'b1);
    chk32("bp_b2b_res", resp_result, 32'd5);
    chk1("bp_b2b_id", resp_id, 1'b1);
    tick();

    // Overlap: req1 accepted on the same edge the response is taken
    req0_valid = 1'b1; req0_op = 3'b010; req0_a = 32'd2; req0_b = 32'd2;
    #1;
    chk1("ov_rdy0", req0_ready, 1'b1);
    tick();
    req0_valid = 1'b0;
    tick();
    req1_valid = 1'b1; req1_op = 3'b010; req1_a = 32'd3; req1_b = 32'd3;
    #1;
    chk1("ov_rdy1", req1_ready, 1'b1);
    chk1("ov_rv", resp_valid, 1'b1);
    chk32("ov_res", resp_result, 32'd4);
    tick();
    req1_valid = 1'b0;
    #1;
    chk1("ov_exec_busy", busy, 1'b1);
    chk1("ov_exec_rv", resp_valid, 1'b0);
    tick();
    #1;
    chk1("ov_rv2", resp_valid, 1'b1);
    chk32("ov_res2", resp_result, 32'd6);
    chk1("ov_id2", resp_id, 1'b1);
    tick();

    // Reset in EXEC: result dropped, priority back to requester 0
    req0_valid = 1'b1; req0_op = 3'b010; req0_a = 32'd100; req0_b = 32'd1;
    #1;
    chk1("rx_rdy0", req0_ready, 1'b1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    chk1("rx_rv", resp_valid, 1'b0);
    chk1("rx_busy", busy, 1'b0);
    chk1("rx_rdy0", req0_ready, 1'b0);
    chk1("rx_rdy1", req1_ready, 1'b0);
    chk1("rx_id", resp_id, 1'b0);
    chk32("rx_res", resp_result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    req1_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk1("rx_after_rv", resp_valid, 1'b0);
      tick();
    end
    req0_valid = 1'b1; req0_op = 3'b010; req0_a = 32'd1; req0_b = 32'd1;
    req1_valid = 1'b1; req1_op = 3'b010; req1_a = 32'd2; req1_b = 32'd2;
    #1;
    chk1("rx_prio_rdy0", req0_ready, 1'b1);
    chk1("rx_prio_rdy1", req1_ready, 1'b0);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    #1;
    chk32("rx_prio_res", resp_result, 32'd2);
    chk1("rx_prio_id", resp_id, 1'b0);
    tick();

    // Random traffic against the transaction-level model
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_prio = 1'b0; m_inflight = 1'b0; m_shown = 1'b0; m_id = 1'b0; m_res = 32'd0;
    for (int r = 0; r < 2; r++) begin
      pv[r] = 1'b0; pop[r] = 3'd0; pa[r] = 32'd0; pb[r] = 32'd0;
    end
    for (int c = 0; c < 3000; c++) begin
      logic win, g0, g1, e0, e1;
      int   sel;
      for (int r = 0; r < 2; r++) begin
        if (!pv[r] && ($urandom_range(0, 2) != 0)) begin
          pv[r]  = 1'b1;
          pop[r] = 3'($urandom_range(0, 7));
          pa[r]  = $urandom;
          pb[r]  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
        end
      end
      req0_valid = pv[0]; req0_op = pop[0]; req0_a = pa[0]; req0_b = pb[0];
      req1_valid = pv[1]; req1_op = pop[1]; req1_a = pa[1]; req1_b = pb[1];
      resp_ready = ($urandom_range(0, 3) != 0);
      #1;
      win = !m_inflight || (m_shown && resp_ready);
      g0  = pv[0] && (!pv[1] || !m_prio);
      g1  = pv[1] && (!pv[0] || m_prio);
      e0  = win && g0;
      e1  = win && g1;
      chk1("rnd_rdy0", req0_ready, e0);
      chk1("rnd_rdy1", req1_ready, e1);
      chk1("rnd_rv", resp_valid, m_shown);
      chk1("rnd_busy", busy, m_inflight);
      if (m_shown) begin
        chk32("rnd_res", resp_result, m_res);
        chk1("rnd_id", resp_id, m_id);
      end
      @(posedge clk);
      if (e0 || e1) begin
        sel        = e1 ? 1 : 0;
        m_res      = ref_alu(pop[sel], pa[sel], pb[sel]);
        m_id       = e1;
        m_inflight = 1'b1;
        m_shown    = 1'b0;
        m_prio     = !e1;
        pv[sel]    = 1'b0;
      end else if (m_inflight && !m_shown) begin
        m_shown = 1'b1;
      end else if (m_shown && resp_ready) begin
        m_inflight = 1'b0;
        m_shown    = 1'b0;
      end
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
